// File: rtl/cnn_pkg.sv
// Shared CNN datapath helpers: FP bit constants, sign-based ReLU, non-negative float max.
package cnn_pkg;

  localparam int unsigned FP_W = 32;

  typedef logic [FP_W-1:0] fp_t;

  localparam fp_t FP_ZERO = fp_t'(0);

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_state_e;

  // Any sign-set pattern (-0.0, negative NaN) collapses to +0.0.
  function automatic fp_t relu_fp(input fp_t x);
    return x[FP_W-1] ? FP_ZERO : x;
  endfunction

  // Valid for sign-clear operands only: IEEE ordering equals unsigned bit ordering.
  function automatic fp_t max_nonneg_fp(input fp_t a, input fp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_relu_2x2_line_buffer.sv
// Half-row store of horizontal pair maxima: one synchronous write port, one async read port.
module pool_line_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 28,
  parameter int unsigned AW         = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Not reset: every slot is rewritten on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/maxpool_relu_2x2.sv
// Streaming ReLU + 2x2/stride-2 max-pool over a raster-order single-precision pixel stream.
module maxpool_relu_2x2
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIDTH      = 56,
  parameter int unsigned HEIGHT     = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int unsigned POOL_W = WIDTH / 2;
  localparam int unsigned CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned AW     = (POOL_W > 1) ? $clog2(POOL_W) : 1;

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  row_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] relu_c;
  logic [DATA_WIDTH-1:0] pm_c;
  logic                  lb_we;
  logic [AW-1:0]         lb_addr;
  logic [DATA_WIDTH-1:0] lb_rdata;

  assign relu_c  = relu_fp(data_in);
  assign pm_c    = max_nonneg_fp(pair_q, relu_c);
  assign lb_addr = AW'(col_q >> 1);

  pool_line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (POOL_W),
    .AW        (AW)
  ) u_line_buf (
    .clk  (clk),
    .we   (lb_we),
    .waddr(lb_addr),
    .wdata(pm_c),
    .raddr(lb_addr),
    .rdata(lb_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= ROW_EVEN;
      pair_q  <= FP_ZERO;
      valid_q <= 1'b0;
      data_q  <= FP_ZERO;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      pair_q  <= pair_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Position counters, row-parity FSM, pair/window reduction.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    pair_d  = pair_q;
    valid_d = 1'b0;
    data_d  = data_q;
    done_d  = 1'b0;
    lb_we   = 1'b0;

    if (valid_in) begin
      if (!col_q[0]) begin
        pair_d = relu_c;
      end else if (state_q == ROW_EVEN) begin
        lb_we = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = max_nonneg_fp(lb_rdata, pm_c);
        done_d  = (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));
      end

      if (col_q == CW'(WIDTH - 1)) begin
        col_d   = '0;
        row_d   = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
        state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  assign valid_out  = valid_q;
  assign data_out   = data_q;
  assign frame_done = done_q;

endmodule
